// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation from RENAME, out-of-order
// completion by tag, in-order retirement at one per cycle. Each retirement
// returns the destination's previous physical register to the free pool.

// One buffer slot: status bits plus the rename payload carried to retirement.
module rob_entry #(
  parameter int PREG_W = 7,
  parameter int AREG_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              alloc_we,
  input  logic              alloc_hasdest,
  input  logic [AREG_W-1:0] alloc_areg,
  input  logic [PREG_W-1:0] alloc_preg,
  input  logic [PREG_W-1:0] alloc_oldpreg,
  input  logic              complete_we,
  input  logic              retire_clr,
  output logic              valid,
  output logic              done,
  output logic              hasdest,
  output logic [AREG_W-1:0] areg,
  output logic [PREG_W-1:0] preg,
  output logic [PREG_W-1:0] oldpreg
);

  // Status bits: flush wins, then allocation, then retirement, then completion.
  // Allocation and retirement never target the same slot (head valid implies
  // tail != head unless full, and full blocks allocation).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      done  <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
      done  <= 1'b0;
    end else if (alloc_we) begin
      valid <= 1'b1;
      done  <= 1'b0;
    end else if (retire_clr) begin
      valid <= 1'b0;
      done  <= 1'b0;
    end else if (complete_we && valid) begin
      done  <= 1'b1;
    end
  end

  // Payload captured at allocation; meaningless while the slot is invalid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hasdest <= 1'b0;
      areg    <= '0;
      preg    <= '0;
      oldpreg <= '0;
    end else if (alloc_we && !flush) begin
      hasdest <= alloc_hasdest;
      areg    <= alloc_areg;
      preg    <= alloc_preg;
      oldpreg <= alloc_oldpreg;
    end
  end

endmodule

module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int PREG_W = 7,
  parameter int AREG_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alloc_valid,
  input  logic              alloc_hasdest,
  input  logic [AREG_W-1:0] alloc_areg,
  input  logic [PREG_W-1:0] alloc_preg,
  input  logic [PREG_W-1:0] alloc_oldpreg,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              complete_valid,
  input  logic [TAG_W-1:0]  complete_tag,
  input  logic              flush,
  output logic              freepreg,
  output logic [PREG_W-1:0] pregtofree,
  output logic              retire_valid,
  output logic [AREG_W-1:0] retire_areg,
  output logic [PREG_W-1:0] retire_preg,
  output logic [TAG_W:0]    count,
  output logic              empty
);

  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0]             e_valid;
  logic [DEPTH-1:0]             e_done;
  logic [DEPTH-1:0]             e_hasdest;
  logic [DEPTH-1:0][AREG_W-1:0] e_areg;
  logic [DEPTH-1:0][PREG_W-1:0] e_preg;
  logic [DEPTH-1:0][PREG_W-1:0] e_oldpreg;

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic             alloc_fire;
  logic             retire_fire;

  // Full/empty come from count alone; head==tail is ambiguous.
  assign alloc_ready = (count != FULL);
  assign alloc_tag   = tail;
  assign empty       = (count == '0);

  assign alloc_fire  = alloc_valid && alloc_ready && !flush;
  assign retire_fire = e_valid[head] && e_done[head] && !flush;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    rob_entry #(
      .PREG_W (PREG_W),
      .AREG_W (AREG_W)
    ) u_entry (
      .clk           (clk),
      .reset_n       (reset_n),
      .flush         (flush),
      .alloc_we      (alloc_fire && (tail == TAG_W'(g))),
      .alloc_hasdest (alloc_hasdest),
      .alloc_areg    (alloc_areg),
      .alloc_preg    (alloc_preg),
      .alloc_oldpreg (alloc_oldpreg),
      .complete_we   (complete_valid && !flush && (complete_tag == TAG_W'(g))),
      .retire_clr    (retire_fire && (head == TAG_W'(g))),
      .valid         (e_valid[g]),
      .done          (e_done[g]),
      .hasdest       (e_hasdest[g]),
      .areg          (e_areg[g]),
      .preg          (e_preg[g]),
      .oldpreg       (e_oldpreg[g])
    );
  end

  // Head/tail wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_fire)  tail <= tail + 1'b1;
      if (retire_fire) head <= head + 1'b1;
      case ({alloc_fire, retire_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered retirement outputs; p0 is architecturally pinned and never freed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retire_valid <= 1'b0;
      retire_areg  <= '0;
      retire_preg  <= '0;
      freepreg     <= 1'b0;
      pregtofree   <= '0;
    end else if (retire_fire) begin
      retire_valid <= 1'b1;
      retire_areg  <= e_areg[head];
      retire_preg  <= e_preg[head];
      if (e_hasdest[head] && (e_oldpreg[head] != '0)) begin
        freepreg   <= 1'b1;
        pregtofree <= e_oldpreg[head];
      end else begin
        freepreg   <= 1'b0;
      end
    end else begin
      retire_valid <= 1'b0;
      freepreg     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus a random run, all checked
// against an in-order queue model of the buffer.
module tb_reorder_buffer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       alloc_valid = 1'b0, alloc_hasdest = 1'b0;
  logic [4:0] alloc_areg = '0;
  logic [6:0] alloc_preg = '0, alloc_oldpreg = '0;
  logic       alloc_ready;
  logic [3:0] alloc_tag;
  logic       complete_valid = 1'b0;
  logic [3:0] complete_tag = '0;
  logic       flush = 1'b0;
  logic       freepreg;
  logic [6:0] pregtofree;
  logic       retire_valid;
  logic [4:0] retire_areg;
  logic [6:0] retire_preg;
  logic [4:0] count;
  logic       empty;

  int total = 0;
  int bad = 0;

  reorder_buffer dut (
    .clk(clk), .reset_n(reset_n),
    .alloc_valid(alloc_valid), .alloc_hasdest(alloc_hasdest),
    .alloc_areg(alloc_areg), .alloc_preg(alloc_preg), .alloc_oldpreg(alloc_oldpreg),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .complete_valid(complete_valid), .complete_tag(complete_tag), .flush(flush),
    .freepreg(freepreg), .pregtofree(pregtofree),
    .retire_valid(retire_valid), .retire_areg(retire_areg), .retire_preg(retire_preg),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0] tag;
    bit         hasdest;
    logic [4:0] areg;
    logic [6:0] preg;
    logic [6:0] old;
    bit         done;
  } ent_t;

  ent_t       q[$];
  logic [3:0] m_tail;
  bit         m_rv, m_fp;
  logic [6:0] m_ptf, m_rpreg;
  logic [4:0] m_rareg;

  function automatic void model_reset();
    q.delete();
    m_tail = 0; m_rv = 0; m_fp = 0; m_ptf = 0; m_rpreg = 0; m_rareg = 0;
  endfunction

  // Apply one clock edge to the model using the currently driven inputs.
  function automatic void model_edge();
    bit   ret, alc;
    ent_t h;
    if (flush) begin
      q.delete(); m_tail = 0; m_rv = 0; m_fp = 0;
      return;
    end
    ret = (q.size() > 0) && q[0].done;
    alc = alloc_valid && (q.size() < 16);
    if (complete_valid)
      foreach (q[i]) if (q[i].tag == complete_tag) q[i].done = 1;
    if (ret) begin
      h = q.pop_front();
      m_rv = 1; m_rareg = h.areg; m_rpreg = h.preg;
      if (h.hasdest && h.old != 0) begin m_fp = 1; m_ptf = h.old; end
      else m_fp = 0;
    end else begin
      m_rv = 0; m_fp = 0;
    end
    if (alc) begin
      h.tag = m_tail; h.hasdest = alloc_hasdest; h.areg = alloc_areg;
      h.preg = alloc_preg; h.old = alloc_oldpreg; h.done = 0;
      q.push_back(h);
      m_tail = m_tail + 1;
    end
  endfunction

  // Expected {count,empty,alloc_ready,alloc_tag,retire_valid,freepreg,pregtofree,retire_areg,retire_preg}
  function automatic logic [31:0] exp_vec();
    return {5'(q.size()), q.size() == 0, q.size() < 16, m_tail, m_rv, m_fp, m_ptf, m_rareg, m_rpreg};
  endfunction

  logic [31:0] act_vec;
  assign act_vec = {count, empty, alloc_ready, alloc_tag, retire_valid, freepreg, pregtofree, retire_areg, retire_preg};

  // One cycle: drive inputs, advance the model, sample #1 after the edge.
  task automatic cyc(input bit av, input bit hd, input logic [4:0] ar, input logic [6:0] pr,
                     input logic [6:0] op, input bit cv, input logic [3:0] ct, input bit fl);
    alloc_valid = av; alloc_hasdest = hd; alloc_areg = ar; alloc_preg = pr; alloc_oldpreg = op;
    complete_valid = cv; complete_tag = ct; flush = fl;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    model_reset();
    #12;
    total++;
    if (act_vec !== exp_vec()) begin
      bad++; $display("FAIL reset_state act=%h exp=%h", act_vec, exp_vec());
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    idle();
    total++;
    if (act_vec !== exp_vec()) begin
      bad++; $display("FAIL reset_idle act=%h exp=%h", act_vec, exp_vec());
    end
  endtask

  task automatic test_order();
    idle(); cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 5'(i + 1), 7'(40 + i), 7'(33 + i), 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 2, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 0);
    total++;
    if (retire_valid !== 1'b0 || count !== 5'd3) begin
      bad++; $display("FAIL order_hold rv=%b cnt=%0d exp rv=0 cnt=3", retire_valid, count);
    end
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    total++;
    if (retire_valid !== 1'b0) begin
      bad++; $display("FAIL order_hold0 rv=%b exp 0", retire_valid);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      total++;
      if (freepreg !== 1'b1 || pregtofree !== 7'(33 + i) || act_vec !== exp_vec()) begin
        bad++; $display("FAIL order_free%0d fp=%b ptf=%0d vec=%h exp fp=1 ptf=%0d vec=%h",
                        i, freepreg, pregtofree, act_vec, 33 + i, exp_vec());
      end
    end
    idle();
    total++;
    if (freepreg !== 1'b0 || empty !== 1'b1) begin
      bad++; $display("FAIL order_end fp=%b empty=%b exp fp=0 empty=1", freepreg, empty);
    end
  endtask

  task automatic test_fill();
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, 5'(i), 7'(64 + i), 7'(i + 1), 0, 0, 0);
      total++;
      if (act_vec !== exp_vec()) begin
        bad++; $display("FAIL fill_%0d act=%h exp=%h", i, act_vec, exp_vec());
      end
    end
    total++;
    if (alloc_ready !== 1'b0 || count !== 5'd16) begin
      bad++; $display("FAIL fill_full rdy=%b cnt=%0d exp rdy=0 cnt=16", alloc_ready, count);
    end
    cyc(1, 1, 5'd31, 7'd127, 7'd99, 0, 0, 0);
    total++;
    if (count !== 5'd16 || alloc_tag !== 4'd0) begin
      bad++; $display("FAIL fill_ignored cnt=%0d tag=%0d exp cnt=16 tag=0", count, alloc_tag);
    end
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    total++;
    if (alloc_ready !== 1'b1 || count !== 5'd15 || alloc_tag !== 4'd0 || pregtofree !== 7'd1) begin
      bad++; $display("FAIL fill_wrap rdy=%b cnt=%0d tag=%0d ptf=%0d exp rdy=1 cnt=15 tag=0 ptf=1",
                      alloc_ready, count, alloc_tag, pregtofree);
    end
    cyc(1, 1, 5'd7, 7'd100, 7'd77, 0, 0, 0);
    total++;
    if (act_vec !== exp_vec() || count !== 5'd16) begin
      bad++; $display("FAIL fill_realloc act=%h exp=%h", act_vec, exp_vec());
    end
  endtask

  task automatic test_nofree();
    int rv_seen = 0, fp_seen = 0;
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 5'd3, 7'd20, 7'd50, 0, 0, 0);
    cyc(1, 1, 5'd4, 7'd21, 7'd0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      if (retire_valid) rv_seen++;
      if (freepreg) fp_seen++;
      idle();
    end
    total++;
    if (rv_seen != 2 || fp_seen != 0 || act_vec !== exp_vec()) begin
      bad++; $display("FAIL nofree rv=%0d fp=%0d exp rv=2 fp=0 vec=%h/%h", rv_seen, fp_seen, act_vec, exp_vec());
    end
  endtask

  task automatic test_steady();
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 1, 5'(i), 7'(10 + i), 7'(90 + i), 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, q[0].tag, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 5'(i + 8), 7'(18 + i), 7'(98 + i), 1, q[1].tag, 0);
      total++;
      if (count !== 5'd8 || freepreg !== 1'b1 || act_vec !== exp_vec()) begin
        bad++; $display("FAIL steady_%0d cnt=%0d fp=%b act=%h exp cnt=8 fp=1 vec=%h",
                        i, count, freepreg, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_flush();
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 5'(i), 7'(30 + i), 7'(60 + i), 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 1, 5'd9, 7'd9, 7'd9, 1, 1, 1);
    total++;
    if (count !== 5'd0 || empty !== 1'b1 || retire_valid !== 1'b0 || freepreg !== 1'b0 || alloc_tag !== 4'd0) begin
      bad++; $display("FAIL flush cnt=%0d empty=%b rv=%b fp=%b tag=%0d exp 0/1/0/0/0",
                      count, empty, retire_valid, freepreg, alloc_tag);
    end
    idle();
    total++;
    if (act_vec !== exp_vec()) begin
      bad++; $display("FAIL flush_after act=%h exp=%h", act_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 1), 5'($urandom), 7'($urandom),
          ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom),
          $urandom_range(0, 9) < 6, 4'($urandom), $urandom_range(0, 63) == 0);
      total++;
      if (act_vec !== exp_vec()) begin
        bad++;
        if (errs++ < 10) $display("FAIL random_%0d act=%h exp=%h", i, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_midrun();
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 1, 5'(i), 7'(50 + i), 7'(70 + i), 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 2, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (count !== 5'd0 || empty !== 1'b1 || alloc_ready !== 1'b1 || freepreg !== 1'b0 || retire_valid !== 1'b0) begin
      bad++; $display("FAIL reset_async cnt=%0d empty=%b rdy=%b fp=%b rv=%b exp 0/1/1/0/0",
                      count, empty, alloc_ready, freepreg, retire_valid);
    end
    @(posedge clk); #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (alloc_tag !== 4'd0 || act_vec !== exp_vec()) begin
      bad++; $display("FAIL reset_release tag=%0d act=%h exp=%h", alloc_tag, act_vec, exp_vec());
    end
    cyc(1, 1, 5'd1, 7'd2, 7'd3, 0, 0, 0);
    total++;
    if (count !== 5'd1 || alloc_tag !== 4'd1) begin
      bad++; $display("FAIL reset_first_alloc cnt=%0d tag=%0d exp cnt=1 tag=1", count, alloc_tag);
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_fill();
    test_nofree();
    test_steady();
    test_flush();
    test_random();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
